// File: rtl/simple_ctrl_pkg.sv
// rtl/simple_ctrl_pkg.sv - shared types and IR field positions for the control sequencer
package simple_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        RD_A   = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [3:0] CLS_NOP  = 4'h0;
    localparam logic [3:0] CLS_ALU  = 4'h1;
    localparam logic [3:0] CLS_LDI  = 4'h2;
    localparam logic [3:0] CLS_JMP  = 4'h3;
    localparam logic [3:0] CLS_JZ   = 4'h4;
    localparam logic [3:0] CLS_HALT = 4'hF;

    localparam int IR_CLS_MSB = 15;
    localparam int IR_CLS_LSB = 12;
    localparam int IR_RD_MSB  = 11;
    localparam int IR_RD_LSB  = 10;
    localparam int IR_RS_MSB  = 9;
    localparam int IR_RS_LSB  = 8;
    localparam int IR_IMM_MSB = 7;
    localparam int IR_IMM_LSB = 0;
    localparam int IR_OP_MSB  = 2;
    localparam int IR_OP_LSB  = 0;

    // Any class outside the defined set is reported as illegal and skipped
    function automatic logic is_legal_cls(input logic [3:0] cls);
        return (cls == CLS_NOP) || (cls == CLS_ALU) || (cls == CLS_LDI) ||
               (cls == CLS_JMP) || (cls == CLS_JZ)  || (cls == CLS_HALT);
    endfunction

endpackage

// File: rtl/simple_ctrl_seq.sv
// rtl/simple_ctrl_seq.sv - multi-cycle fetch/decode control sequencer for simple_top
module simple_ctrl_seq
    import simple_ctrl_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_valid,
    input  logic [15:0]     instruction_wire,
    input  logic            alu_zero,
    output logic [1:0]      RF_addr,
    output logic            RF_we,
    output logic            A_re,
    output logic            ALU_ce,
    output logic [2:0]      ALU_opcode_wire,
    output logic [7:0]      imm,
    output logic            imm_sel,
    output logic            halted,
    output logic            illegal
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    // Low only until the first edge after reset, so no fetch is requested during reset
    logic            run_q, run_d;

    logic [3:0]      cls;
    logic [1:0]      rd;
    logic [1:0]      rs;
    logic [2:0]      op;
    logic [PC_W-1:0] imm_pc;

    assign cls    = ir_q[IR_CLS_MSB:IR_CLS_LSB];
    assign rd     = ir_q[IR_RD_MSB:IR_RD_LSB];
    assign rs     = ir_q[IR_RS_MSB:IR_RS_LSB];
    assign op     = ir_q[IR_OP_MSB:IR_OP_LSB];
    assign imm_pc = PC_W'(ir_q[IR_IMM_MSB:IR_IMM_LSB]);

    assign imem_addr = pc_q;
    assign imm       = ir_q[IR_IMM_MSB:IR_IMM_LSB];

    // State, PC and IR registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            run_q   <= run_d;
        end
    end

    // Next state, PC update and instruction capture
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        run_d   = 1'b1;
        case (state_q)
            FETCH: begin
                if (run_q && imem_valid) begin
                    ir_d    = instruction_wire;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                pc_d    = pc_q + PC_W'(1);
                state_d = FETCH;
                case (cls)
                    CLS_ALU: state_d = RD_A;
                    CLS_LDI: state_d = WB;
                    CLS_JMP: pc_d = imm_pc;
                    CLS_JZ:  if (alu_zero) pc_d = imm_pc;
                    CLS_HALT: begin
                        pc_d    = pc_q;
                        state_d = HALT;
                    end
                    default: state_d = FETCH;
                endcase
            end
            RD_A:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Moore output decode from state and IR only
    always_comb begin
        imem_req        = 1'b0;
        RF_addr         = 2'd0;
        RF_we           = 1'b0;
        A_re            = 1'b0;
        ALU_ce          = 1'b0;
        ALU_opcode_wire = 3'd0;
        imm_sel         = 1'b0;
        halted          = 1'b0;
        illegal         = 1'b0;
        case (state_q)
            FETCH:  imem_req = run_q;
            DECODE: illegal = !is_legal_cls(cls);
            RD_A: begin
                RF_addr = rd;
                A_re    = 1'b1;
            end
            EXEC: begin
                RF_addr         = rs;
                ALU_ce          = 1'b1;
                ALU_opcode_wire = op;
            end
            WB: begin
                RF_addr = rd;
                RF_we   = 1'b1;
                imm_sel = (cls == CLS_LDI);
            end
            HALT:    halted = 1'b1;
            default: imem_req = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_simple_ctrl_seq.sv
// tb/tb_simple_ctrl_seq.sv - scoreboard bench for simple_ctrl_seq against an instruction-level model
module tb_simple_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic        imem_valid;
    logic [15:0] instruction_wire;
    logic        alu_zero;
    logic [1:0]  RF_addr;
    logic        RF_we;
    logic        A_re;
    logic        ALU_ce;
    logic [2:0]  ALU_opcode_wire;
    logic [7:0]  imm;
    logic        imm_sel;
    logic        halted;
    logic        illegal;

    simple_ctrl_seq #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_addr        (imem_addr),
        .imem_req         (imem_req),
        .imem_valid       (imem_valid),
        .instruction_wire (instruction_wire),
        .alu_zero         (alu_zero),
        .RF_addr          (RF_addr),
        .RF_we            (RF_we),
        .A_re             (A_re),
        .ALU_ce           (ALU_ce),
        .ALU_opcode_wire  (ALU_opcode_wire),
        .imm              (imm),
        .imm_sel          (imm_sel),
        .halted           (halted),
        .illegal          (illegal)
    );

    always #5 clk = ~clk;

    // kind: 0 fetch, 1 A load, 2 ALU exec, 3 RF write, 4 illegal; off = cycles after fetch accept
    typedef struct {
        int kind;
        int a;
        int op;
        int im;
        int sel;
        int off;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] mem [256];
    bit          zero_tab [256];
    int          valid_pct = 0;
    bit          armed = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic ev_t mk(input int k, input int a, input int o, input int im, input int s, input int of);
        ev_t e;
        e = '{k, a, o, im, s, of};
        return e;
    endfunction

    // Instruction-level model: walks the program and lists the externally visible events
    task automatic build_expect(input int n);
        int pc;
        logic [15:0] ins;
        int cls, rd, rs, op, im;
        pc = 0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            ins = mem[pc];
            cls = int'(ins[15:12]);
            rd  = int'(ins[11:10]);
            rs  = int'(ins[9:8]);
            im  = int'(ins[7:0]);
            op  = int'(ins[2:0]);
            exp_q.push_back(mk(0, pc, 0, 0, 0, 0));
            if (cls == 15) break;
            case (cls)
                0: pc = (pc + 1) % 256;
                1: begin
                    exp_q.push_back(mk(1, rd, 0, 0, 0, 2));
                    exp_q.push_back(mk(2, rs, op, 0, 0, 3));
                    exp_q.push_back(mk(3, rd, 0, im, 0, 4));
                    pc = (pc + 1) % 256;
                end
                2: begin
                    exp_q.push_back(mk(3, rd, 0, im, 1, 2));
                    pc = (pc + 1) % 256;
                end
                3: pc = im;
                4: pc = zero_tab[pc] ? im : (pc + 1) % 256;
                default: begin
                    exp_q.push_back(mk(4, 0, 0, 0, 0, 1));
                    pc = (pc + 1) % 256;
                end
            endcase
        end
    endtask

    // Instruction memory and zero-flag stimulus, changed away from the active edge
    initial begin
        imem_valid       = 1'b0;
        instruction_wire = 16'h0000;
        alu_zero         = 1'b0;
        forever begin
            logic [31:0] junk;
            @(negedge clk);
            junk             = $urandom;
            imem_valid       = ($urandom_range(0, 99) < valid_pct);
            instruction_wire = imem_valid ? mem[imem_addr] : junk[15:0];
            alu_zero         = zero_tab[imem_addr];
        end
    end

    // Monitor: turns each cycle's outputs into an event and checks it against the queue
    initial begin
        int  cyc;
        int  lastf;
        ev_t o;
        ev_t e;
        bit  have;
        cyc   = 0;
        lastf = 0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (armed) begin
                chk("one_enable", int'(A_re) + int'(ALU_ce) + int'(RF_we) > 1 ? 1 : 0, 0);
                chk("opcode_idle", (!ALU_ce) ? int'(ALU_opcode_wire) : 0, 0);
                chk("rf_addr_idle", (!(A_re || ALU_ce || RF_we)) ? int'(RF_addr) : 0, 0);
                chk("halted_run", int'(halted), 0);
                have = 1'b1;
                if (imem_req && imem_valid) begin
                    o = mk(0, int'(imem_addr), 0, 0, 0, 0);
                    lastf = cyc;
                end else if (A_re) o = mk(1, int'(RF_addr), 0, 0, 0, cyc - lastf);
                else if (ALU_ce) o = mk(2, int'(RF_addr), int'(ALU_opcode_wire), 0, 0, cyc - lastf);
                else if (RF_we)  o = mk(3, int'(RF_addr), 0, int'(imm), int'(imm_sel), cyc - lastf);
                else if (illegal) o = mk(4, 0, 0, 0, 0, cyc - lastf);
                else have = 1'b0;
                if (have) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL event_extra: got kind=%0d a=%0d expected no event", o.kind, o.a);
                    end else begin
                        e = exp_q.pop_front();
                        if (o != e) begin
                            miscompares++;
                            $display("FAIL event: got kind=%0d a=%0h op=%0d imm=%0h sel=%0d off=%0d expected kind=%0d a=%0h op=%0d imm=%0h sel=%0d off=%0d",
                                     o.kind, o.a, o.op, o.im, o.sel, o.off, e.kind, e.a, e.op, e.im, e.sel, e.off);
                        end
                    end
                    if (exp_q.size() == 0) armed = 1'b0;
                end
            end
        end
    end

    // Releases reset and lets the monitor consume the model's events, within a cycle budget
    task automatic run_program(input int n, input int pct);
        build_expect(n);
        valid_pct = pct;
        armed     = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 20000 && armed; c++) @(negedge clk);
        if (armed) begin
            miscompares++;
            $display("FAIL run_timeout: got %0d events pending expected 0", exp_q.size());
            armed = 1'b0;
            exp_q.delete();
        end
    endtask

    task automatic fill_random;
        logic [31:0] r;
        logic [3:0]  c;
        for (int i = 0; i < 256; i++) begin
            r = $urandom;
            case ($urandom_range(0, 9))
                0:       c = 4'h0;
                1, 2, 3: c = 4'h1;
                4, 5:    c = 4'h2;
                6:       c = 4'h3;
                7:       c = 4'h4;
                8:       c = 4'($urandom_range(5, 14));
                default: c = 4'h1;
            endcase
            mem[i]      = {c, r[11:0]};
            zero_tab[i] = r[31];
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]      = 16'h0000;
            zero_tab[i] = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", int'(imem_req), 0);
        chk("rst_addr", int'(imem_addr), 0);
        chk("rst_enables", int'({RF_we, A_re, ALU_ce, imm_sel, halted, illegal}), 0);
        chk("rst_fields", int'({RF_addr, ALU_opcode_wire, imm}), 0);

        // Fetch stall with no valid instruction
        valid_pct = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("stall_req", int'(imem_req), 1);
            chk("stall_addr", int'(imem_addr), 0);
            chk("stall_enables", int'({RF_we, A_re, ALU_ce, illegal}), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed program: ALU, LDI, JZ not taken, JZ taken, illegal, JMP, NOP with wrap
        mem[8'h00] = 16'h1602;
        mem[8'h01] = 16'h2C5A;
        mem[8'h02] = 16'h4010;
        mem[8'h03] = 16'h4010;
        zero_tab[8'h02] = 1'b0;
        zero_tab[8'h03] = 1'b1;
        mem[8'h10] = 16'h7000;
        mem[8'h11] = 16'h30FF;
        mem[8'hFF] = 16'h0000;
        run_program(8, 100);
        @(negedge clk);
        rst = 1'b0;

        // HALT holds until reset
        mem[8'h00] = 16'hF000;
        run_program(1, 100);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            chk("halt_flag", int'(halted), 1);
            chk("halt_quiet", int'({imem_req, RF_we, A_re, ALU_ce}), 0);
        end

        // Reset during EXEC of an ALU instruction aborts it
        @(negedge clk);
        rst = 1'b0;
        mem[8'h00] = 16'h1602;
        valid_pct  = 100;
        @(negedge clk);
        rst   = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            #1;
            if (ALU_ce) found = 1'b1;
        end
        chk("exec_reached", int'(found), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_enables", int'({RF_we, A_re, ALU_ce, imem_req, halted}), 0);
        chk("abort_addr", int'(imem_addr), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("abort_no_we", int'({RF_we, imem_req}), 0);
        end

        // Random programs with random fetch stalls, restarting from RESET_PC
        fill_random();
        run_program(200, 70);
        @(negedge clk);
        rst = 1'b0;
        fill_random();
        run_program(200, 40);
        @(negedge clk);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
